// File: rtl/systolic_result_deskewer.sv
// systolic_result_deskewer
// Realigns the diagonally skewed column results of a systolic array into
// whole vectors and buffers them in a show-ahead FIFO with a ready/valid
// output. The array cannot stall, so a completed vector that finds the FIFO
// full (and not draining) is dropped and a sticky overflow flag is raised.
module systolic_result_deskewer #(
  parameter int DATA_WIDTH = 8,
  parameter int COLUMNS    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_WIDTH*COLUMNS-1:0]       result_in,
  input  logic                                result_valid,
  output logic [DATA_WIDTH*COLUMNS-1:0]       out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                overflow,
  input  logic                                clear_overflow
);

  localparam int VW = DATA_WIDTH * COLUMNS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [VW-1:0] w_vec;
  logic          w_push;

  // Lane c is delayed COLUMNS-1-c cycles so every column lines up with the
  // last column, which arrives latest and feeds the FIFO directly.
  for (genvar c = 0; c < COLUMNS; c++) begin : g_lane
    if (c == COLUMNS - 1) begin : g_direct
      assign w_vec[c*DATA_WIDTH +: DATA_WIDTH] = result_in[c*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_shift
      localparam int LEN = COLUMNS - 1 - c;
      logic [DATA_WIDTH-1:0] r_sr [LEN];

      // Shift this column's element along until the last column catches up.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LEN; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= result_in[c*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < LEN; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign w_vec[c*DATA_WIDTH +: DATA_WIDTH] = r_sr[LEN-1];
    end
  end

  // The start-of-vector marker travels with the slowest lane delay so that it
  // emerges exactly when the assembled vector is complete.
  if (COLUMNS > 1) begin : g_vpipe
    logic [COLUMNS-2:0] r_vld;

    // Delay result_valid by COLUMNS-1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= result_valid;
        for (int i = 1; i < COLUMNS - 1; i++) r_vld[i] <= r_vld[i-1];
      end
    end

    assign w_push = r_vld[COLUMNS-2];
  end else begin : g_vdirect
    assign w_push = result_valid;
  end

  logic [VW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_full;
  logic w_pop;
  logic w_accept;
  logic w_drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle,
  // because the freed slot is exactly the one the write pointer addresses.
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_pop    = (r_count != '0) && out_ready;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  // Vector storage; cleared on reset so out_data reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_accept) begin
      r_mem[r_wptr] <= w_vec;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + PW'(1);
      if (w_pop)    r_rptr <= r_rptr + PW'(1);
      if (w_accept && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_accept) r_count <= r_count - CW'(1);
    end
  end

  // Sticky loss flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_data  = r_mem[r_rptr];
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_systolic_result_deskewer.sv
// Testbench for systolic_result_deskewer (COLUMNS=4, DATA_WIDTH=8,
// FIFO_DEPTH=4). Vectors are fed with the array's diagonal skew; expected
// vectors go into a scoreboard queue when issued and are popped when the DUT
// hands a vector over.
module tb_systolic_result_deskewer;

  localparam int C  = 4;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int VW = C * W;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VW-1:0] result_in;
  logic          result_valid;
  logic [VW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clear_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [VW-1:0] q [$];
  bit            hv [C];
  logic [VW-1:0] hd [C];

  systolic_result_deskewer #(
    .DATA_WIDTH(W),
    .COLUMNS   (C),
    .FIFO_DEPTH(D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .result_in     (result_in),
    .result_valid  (result_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .count         (count),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mkvec(input int base);
    logic [VW-1:0] v;
    for (int c = 0; c < C; c++) v[c*W +: W] = W'(base + c);
    return v;
  endfunction

  task automatic clear_hist();
    for (int c = 0; c < C; c++) begin
      hv[c] = 1'b0;
      hd[c] = '0;
    end
  endtask

  // One clock cycle, entered and left at a falling edge: drives the skewed
  // array bus and handshake inputs, reports the outputs of this cycle.
  task automatic step(input bit vld, input logic [VW-1:0] vec, input bit rdy, input bit clr,
                      output logic ov, output logic [VW-1:0] od,
                      output logic [CW-1:0] cnt, output logic ovf);
    logic [VW-1:0] rin;
    for (int c = C - 1; c > 0; c--) begin
      hv[c] = hv[c-1];
      hd[c] = hd[c-1];
    end
    hv[0] = vld;
    hd[0] = vec;
    for (int c = 0; c < C; c++)
      rin[c*W +: W] = hv[c] ? hd[c][c*W +: W] : W'($urandom);
    result_in      = rin;
    result_valid   = vld;
    out_ready      = rdy;
    clear_overflow = clr;
    ov  = out_valid;
    od  = out_data;
    cnt = count;
    ovf = overflow;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; result_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    result_in = '0;
    clear_hist();
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic ov, ovf; logic [VW-1:0] od, exp; logic [CW-1:0] cnt; int nout = 0;
    q.push_back(mkvec(8'h10));
    for (int s = 0; s < 9; s++) begin
      step(s == 0, mkvec(8'h10), 1'b1, 1'b0, ov, od, cnt, ovf);
      if (ov === 1'b1) begin
        nout++;
        n_checks++; if (s != 4) $display("FAIL single_timing got cycle %0d want 4", s); else n_pass++;
        n_checks++;
        if (q.size() == 0) $display("FAIL single_extra got %h want none", od);
        else begin
          exp = q.pop_front();
          if (od !== exp) $display("FAIL single_data got %h want %h", od, exp); else n_pass++;
        end
      end
    end
    n_checks++; if (nout != 1) $display("FAIL single_count_out got %0d want 1", nout); else n_pass++;
    n_checks++; if (count !== '0) $display("FAIL single_count_end got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ov, ovf; logic [VW-1:0] od, exp; logic [CW-1:0] cnt; int nout = 0; int maxcnt = 0;
    for (int s = 0; s < 13; s++) begin
      if (s < 6) q.push_back(mkvec(16 * s));
      step(s < 6, mkvec(16 * s), 1'b1, 1'b0, ov, od, cnt, ovf);
      if (int'(cnt) > maxcnt) maxcnt = int'(cnt);
      if (ov === 1'b1) begin
        n_checks++; if (s != 4 + nout) $display("FAIL b2b_timing got cycle %0d want %0d", s, 4 + nout); else n_pass++;
        nout++;
        n_checks++;
        if (q.size() == 0) $display("FAIL b2b_extra got %h want none", od);
        else begin
          exp = q.pop_front();
          if (od !== exp) $display("FAIL b2b_data got %h want %h", od, exp); else n_pass++;
        end
      end
    end
    n_checks++; if (nout != 6) $display("FAIL b2b_count_out got %0d want 6", nout); else n_pass++;
    n_checks++; if (maxcnt > 1) $display("FAIL b2b_max_count got %0d want <=1", maxcnt); else n_pass++;
  endtask

  task automatic test_overflow();
    logic ov, ovf; logic [VW-1:0] od, exp; logic [CW-1:0] cnt; int nout = 0;
    for (int s = 0; s < 9; s++) begin
      if (s < 4) q.push_back(mkvec(8'h40 + 16 * s));
      step(s < 5, mkvec(8'h40 + 16 * s), 1'b0, 1'b0, ov, od, cnt, ovf);
      if (s == 7) begin
        n_checks++; if (cnt !== CW'(4)) $display("FAIL ovf_full_count got %0d want 4", cnt); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_before_drop got %b want 0", ovf); else n_pass++;
      end
      if (s == 8) begin
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_after_drop got %b want 1", ovf); else n_pass++;
        n_checks++; if (cnt !== CW'(4)) $display("FAIL ovf_count_held got %0d want 4", cnt); else n_pass++;
      end
    end
    for (int s = 0; s < 7; s++) begin
      step(1'b0, '0, 1'b1, 1'b0, ov, od, cnt, ovf);
      if (ov === 1'b1) begin
        nout++;
        n_checks++;
        if (q.size() == 0) $display("FAIL ovf_extra got %h want none", od);
        else begin
          exp = q.pop_front();
          if (od !== exp) $display("FAIL ovf_drain_data got %h want %h", od, exp); else n_pass++;
        end
      end
    end
    n_checks++; if (nout != 4) $display("FAIL ovf_drain_count got %0d want 4", nout); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
    step(1'b0, '0, 1'b1, 1'b1, ov, od, cnt, ovf);
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_full_pop();
    logic ov, ovf; logic [VW-1:0] od, exp; logic [CW-1:0] cnt; int nout = 0;
    for (int s = 0; s < 15; s++) begin
      if (s < 5) q.push_back(mkvec(8'h90 + 16 * s));
      step(s < 5, mkvec(8'h90 + 16 * s), s >= 7, 1'b0, ov, od, cnt, ovf);
      if (s == 7) begin
        n_checks++; if (cnt !== CW'(4)) $display("FAIL fullpop_pre_count got %0d want 4", cnt); else n_pass++;
      end
      if (s == 8) begin
        n_checks++; if (cnt !== CW'(4)) $display("FAIL fullpop_count got %0d want 4", cnt); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL fullpop_overflow got %b want 0", ovf); else n_pass++;
      end
      if (ov === 1'b1 && s >= 7) begin
        nout++;
        n_checks++;
        if (q.size() == 0) $display("FAIL fullpop_extra got %h want none", od);
        else begin
          exp = q.pop_front();
          if (od !== exp) $display("FAIL fullpop_data got %h want %h", od, exp); else n_pass++;
        end
      end
    end
    n_checks++; if (nout != 5) $display("FAIL fullpop_drain_count got %0d want 5", nout); else n_pass++;
  endtask

  task automatic test_collision();
    logic ov, ovf; logic [VW-1:0] od, exp; logic [CW-1:0] cnt; int nout = 0;
    for (int s = 0; s < 9; s++) begin
      if (s < 4) q.push_back(mkvec(8'h05 + 16 * s));
      step(s < 5, mkvec(8'h05 + 16 * s), 1'b0, s == 7, ov, od, cnt, ovf);
      if (s == 8) begin
        n_checks++; if (ovf !== 1'b1) $display("FAIL collide_overflow got %b want 1", ovf); else n_pass++;
      end
    end
    for (int s = 0; s < 7; s++) begin
      step(1'b0, '0, 1'b1, 1'b0, ov, od, cnt, ovf);
      if (ov === 1'b1) begin
        nout++;
        n_checks++;
        if (q.size() == 0) $display("FAIL collide_extra got %h want none", od);
        else begin
          exp = q.pop_front();
          if (od !== exp) $display("FAIL collide_data got %h want %h", od, exp); else n_pass++;
        end
      end
    end
    n_checks++; if (nout != 4) $display("FAIL collide_drain_count got %0d want 4", nout); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic ov, ovf; logic [VW-1:0] od, exp; logic [CW-1:0] cnt; int nout = 0;
    for (int s = 0; s < 5; s++)
      step(s < 3, mkvec(8'hA0 + 16 * s), 1'b0, 1'b0, ov, od, cnt, ovf);
    n_checks++; if (count !== CW'(2)) $display("FAIL midrst_pre_count got %0d want 2", count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL midrst_pre_overflow got %b want 1", overflow); else n_pass++;
    result_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (count !== '0) $display("FAIL midrst_count got %0d want 0", count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL midrst_overflow got %b want 0", overflow); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_hist();
    q.delete();
    q.push_back(mkvec(8'hE0));
    for (int s = 0; s < 10; s++) begin
      step(s == 0, mkvec(8'hE0), 1'b1, 1'b0, ov, od, cnt, ovf);
      if (ov === 1'b1) begin
        nout++;
        n_checks++; if (s != 4) $display("FAIL midrst_timing got cycle %0d want 4", s); else n_pass++;
        n_checks++;
        if (q.size() == 0) $display("FAIL midrst_stale got %h want none", od);
        else begin
          exp = q.pop_front();
          if (od !== exp) $display("FAIL midrst_data got %h want %h", od, exp); else n_pass++;
        end
      end
    end
    n_checks++; if (nout != 1) $display("FAIL midrst_count_out got %0d want 1", nout); else n_pass++;
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_collision();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
